crc_stream_engine: RTL and testbench

- Parametrised streaming CRC engine; successor to the fixed CRC-8 frame checker in the Sigma Delta DAQ shared digital library.
- Configurable CRC width, polynomial, init value and output XOR, plus a multi-byte data path with byte enables.
- Two runtime modes: generate (emit CRC) and check (compare residue).
- Processes back-to-back frames via a done/ack handshake, with no reset between frames; sits between the link deframer and the packet consumer.

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_stream_engine_if.sv | 29 ++
 rtl/crc_byte_step.sv | 24 ++
 rtl/crc_stream_engine.sv | 121 ++++++++++++
 tb/tb_crc_stream_engine.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared types and default constants for the streaming CRC engine.
// The defaults reproduce the legacy CRC-8 frame checker (reflected poly C6).
package crc_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } crc_state_e;

  localparam logic CRC_MODE_CHECK    = 1'b0;
  localparam logic CRC_MODE_GENERATE = 1'b1;

  localparam logic [7:0] CRC8_POLY    = 8'hC6;
  localparam logic [7:0] CRC8_INIT    = 8'h0D;
  localparam logic [7:0] CRC8_XOR_OUT = 8'h00;
  localparam logic [7:0] CRC8_RESIDUE = 8'h00;

endpackage

// File: rtl/crc_stream_engine_if.sv
// Beat stream in from the deframer plus the done/ack result handshake
// towards the packet consumer.
interface crc_stream_engine_if #(
  parameter int CRC_WIDTH  = 8,
  parameter int DATA_BYTES = 1
) ();

  logic                    i_mode;
  logic                    i_valid;
  logic                    o_ready;
  logic [8*DATA_BYTES-1:0] i_data;
  logic [DATA_BYTES-1:0]   i_keep;
  logic                    i_last;
  logic                    o_done;
  logic                    i_ack;
  logic                    o_match;
  logic [CRC_WIDTH-1:0]    o_crc;

  modport master (
    output i_mode, i_valid, i_data, i_keep, i_last, i_ack,
    input  o_ready, o_done, o_match, o_crc
  );

  modport slave (
    input  i_mode, i_valid, i_data, i_keep, i_last, i_ack,
    output o_ready, o_done, o_match, o_crc
  );

endinterface

// File: rtl/crc_byte_step.sv
// Combinational advance of a reflected CRC register by one byte, LSB first.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CRC_WIDTH'(CRC8_POLY)
) (
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic [7:0]           data,
  output logic [CRC_WIDTH-1:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] != data[i]) begin
        crc_out = (crc_out >> 1) ^ CRC_POLY;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Parametrised streaming CRC engine: generate or check mode, multi-byte
// beats with byte enables, back-to-back frames via a done/ack handshake.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH   = 8,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY    = CRC_WIDTH'(CRC8_POLY),
  parameter logic [CRC_WIDTH-1:0] CRC_INIT    = CRC_WIDTH'(CRC8_INIT),
  parameter logic [CRC_WIDTH-1:0] CRC_XOR_OUT = CRC_WIDTH'(CRC8_XOR_OUT),
  parameter logic [CRC_WIDTH-1:0] CRC_RESIDUE = CRC_WIDTH'(CRC8_RESIDUE),
  parameter int                   DATA_BYTES  = 1
) (
  input logic                clk,
  input logic                reset,
  crc_stream_engine_if.slave bus
);

  crc_state_e state_q, state_d;

  logic                  ready;
  logic                  done;
  logic                  load_init;
  logic                  accept;
  logic                  first_q;
  logic                  mode_q;
  logic                  mode_eff;
  logic                  match_q;
  logic [CRC_WIDTH-1:0]  crc_q;
  logic [CRC_WIDTH-1:0]  crc_out_q;
  logic [CRC_WIDTH-1:0]  crc_next;
  logic [DATA_BYTES-1:0] keep_eff;

  logic [CRC_WIDTH-1:0] stage    [DATA_BYTES+1];
  logic [CRC_WIDTH-1:0] step_out [DATA_BYTES];

  // Byte enables only trim the tail of a frame; earlier beats are always full.
  assign keep_eff = bus.i_last ? bus.i_keep : {DATA_BYTES{1'b1}};
  assign stage[0] = crc_q;

  for (genvar b = 0; b < DATA_BYTES; b++) begin : g_chain
    crc_byte_step #(
      .CRC_WIDTH (CRC_WIDTH),
      .CRC_POLY  (CRC_POLY)
    ) u_step (
      .crc_in  (stage[b]),
      .data    (bus.i_data[8*b +: 8]),
      .crc_out (step_out[b])
    );
    assign stage[b+1] = keep_eff[b] ? step_out[b] : stage[b];
  end

  assign crc_next = stage[DATA_BYTES];
  assign accept   = bus.i_valid && ready;
  assign mode_eff = first_q ? bus.i_mode : mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    done      = 1'b0;
    load_init = 1'b0;
    case (state_q)
      INIT: begin
        load_init = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        ready = 1'b1;
        if (bus.i_valid && bus.i_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.i_ack) begin
          state_d = INIT;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // The mode is captured from the first accepted beat, so a one-beat frame
  // must use the live input rather than the not-yet-written latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q     <= CRC_INIT;
      mode_q    <= CRC_MODE_CHECK;
      first_q   <= 1'b1;
      crc_out_q <= CRC_INIT ^ CRC_XOR_OUT;
      match_q   <= 1'b0;
    end else if (load_init) begin
      crc_q   <= CRC_INIT;
      mode_q  <= CRC_MODE_CHECK;
      first_q <= 1'b1;
    end else if (accept) begin
      crc_q   <= crc_next;
      first_q <= 1'b0;
      if (first_q) begin
        mode_q <= bus.i_mode;
      end
      if (bus.i_last) begin
        crc_out_q <= crc_next ^ CRC_XOR_OUT;
        match_q   <= (mode_eff == CRC_MODE_CHECK) && (crc_next == CRC_RESIDUE);
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_done  = done;
  assign bus.o_crc   = crc_out_q;
  assign bus.o_match = match_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine (CRC-8 defaults, 4-byte beats)
// against a bit-serial reference model of the CRC rule.
module tb_crc_stream_engine;

  localparam int         DB     = 4;
  localparam logic [7:0] POLY   = 8'hC6;
  localparam logic [7:0] INITV  = 8'h0D;
  localparam logic [7:0] XOROUT = 8'h00;
  localparam logic [7:0] RESID  = 8'h00;
  localparam int         BOUND  = 50;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        mode;
    int          gap;
  } beat_t;

  typedef beat_t beat_q_t[$];

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  crc_stream_engine_if #(.CRC_WIDTH(8), .DATA_BYTES(DB)) bus ();

  crc_stream_engine #(
    .CRC_WIDTH   (8),
    .CRC_POLY    (POLY),
    .CRC_INIT    (INITV),
    .CRC_XOR_OUT (XOROUT),
    .CRC_RESIDUE (RESID),
    .DATA_BYTES  (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the CRC over the byte sequence the frame delivers, bit by bit.
  function automatic logic [7:0] model_crc(input byte_q_t q);
    logic [7:0] c;
    c = INITV;
    foreach (q[n]) begin
      for (int i = 0; i < 8; i++) begin
        if (c[0] != q[n][i]) c = (c >> 1) ^ POLY;
        else                 c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic byte_q_t frame_bytes(input beat_q_t beats);
    byte_q_t q;
    foreach (beats[b]) begin
      for (int k = 0; k < DB; k++) begin
        if (!beats[b].last || beats[b].keep[k]) q.push_back(beats[b].data[8*k +: 8]);
      end
    end
    return q;
  endfunction

  function automatic beat_t mk(input logic [31:0] data, input logic [3:0] keep,
                               input logic last, input logic mode, input int gap);
    beat_t bt;
    bt.data = data;
    bt.keep = keep;
    bt.last = last;
    bt.mode = mode;
    bt.gap  = gap;
    return bt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input beat_q_t beats);
    int cnt;
    foreach (beats[b]) begin
      repeat (beats[b].gap) tick();
      bus.i_data  = beats[b].data;
      bus.i_keep  = beats[b].keep;
      bus.i_last  = beats[b].last;
      bus.i_mode  = beats[b].mode;
      bus.i_valid = 1'b1;
      cnt = 0;
      while (!bus.o_ready && cnt < BOUND) begin
        tick();
        cnt++;
      end
      chk("ready_wait", 32'(cnt < BOUND), 32'd1);
      tick();
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      bus.i_mode  = ~bus.i_mode;
    end
  endtask

  // Called the cycle after the last beat is accepted; holds DONE, then acks.
  task automatic checkOutput(input string tag, input beat_q_t beats, input int hold);
    logic [7:0] raw;
    logic [7:0] exp_crc;
    logic       exp_match;
    raw       = model_crc(frame_bytes(beats));
    exp_crc   = raw ^ XOROUT;
    exp_match = (beats[0].mode == 1'b0) && (raw == RESID);
    chk({tag, "_done"}, 32'(bus.o_done), 32'd1);
    chk({tag, "_crc"}, 32'(bus.o_crc), 32'(exp_crc));
    chk({tag, "_match"}, 32'(bus.o_match), 32'(exp_match));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold"}, {21'd0, bus.o_ready, bus.o_done, bus.o_crc, bus.o_match},
          {21'd0, 1'b0, 1'b1, exp_crc, exp_match});
    end
    bus.i_ack = 1'b1;
    tick();
    bus.i_ack = 1'b0;
    chk({tag, "_ack"}, {30'd0, bus.o_done, bus.o_ready}, 32'd0);
  endtask

  beat_q_t    beats;
  logic [7:0] c;
  logic [4:0] kmask;
  int         nb;
  int         nk;
  logic       good;
  byte_q_t    pre;

  initial begin
    checks      = 0;
    passes      = 0;
    reset       = 1'b1;
    bus.i_mode  = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_keep  = '0;
    bus.i_last  = 1'b0;
    bus.i_ack   = 1'b0;
    repeat (3) tick();
    chk("reset_ready", 32'(bus.o_ready), 32'd0);
    chk("reset_done", 32'(bus.o_done), 32'd0);
    chk("reset_match", 32'(bus.o_match), 32'd0);
    chk("reset_crc", 32'(bus.o_crc), 32'(INITV ^ XOROUT));
    reset = 1'b0;
    chk("init_ready", 32'(bus.o_ready), 32'd0);
    tick();
    chk("run_ready", 32'(bus.o_ready), 32'd1);

    bus.i_ack = 1'b1;
    tick();
    bus.i_ack = 1'b0;
    chk("stray_ack", {30'd0, bus.o_ready, bus.o_done}, 32'b10);

    beats.delete();
    beats.push_back(mk(32'h0000_0000, 4'b0001, 1'b1, 1'b1, 0));
    applyStimulus(beats);
    chk("gen00_crc_const", 32'(bus.o_crc), 32'h0000_00C7);
    checkOutput("gen00", beats, 0);

    beats.delete();
    beats.push_back(mk(32'h0000_C700, 4'b0011, 1'b1, 1'b0, 0));
    applyStimulus(beats);
    chk("chk_good_const", {23'd0, bus.o_match, bus.o_crc}, 32'h0000_0100);
    checkOutput("chk_good", beats, 0);

    beats.delete();
    beats.push_back(mk(32'h0000_C600, 4'b0011, 1'b1, 1'b0, 0));
    applyStimulus(beats);
    chk("chk_bad_const", {23'd0, bus.o_match, bus.o_crc}, 32'h0000_0013);
    checkOutput("chk_bad", beats, 0);

    beats.delete();
    beats.push_back(mk(32'hABCD_C700, 4'b0001, 1'b1, 1'b0, 0));
    applyStimulus(beats);
    chk("keep1_const", 32'(bus.o_crc), 32'h0000_00C7);
    checkOutput("keep1", beats, 0);

    beats.delete();
    beats.push_back(mk(32'hA5A5_0F0F, 4'b0000, 1'b0, 1'b0, 0));
    beats.push_back(mk(32'h1234_5678, 4'b0010, 1'b0, 1'b1, 2));
    beats.push_back(mk(32'h0000_00C3, 4'b0011, 1'b1, 1'b1, 3));
    applyStimulus(beats);
    checkOutput("gaps", beats, 5);
    beats.delete();
    beats.push_back(mk(32'h0000_C700, 4'b0011, 1'b1, 1'b0, 0));
    applyStimulus(beats);
    chk("b2b_match_const", 32'(bus.o_match), 32'd1);
    checkOutput("b2b", beats, 0);

    // Reset mid-frame, with a last beat presented during reset.
    beats.delete();
    beats.push_back(mk(32'h1234_5678, 4'b1111, 1'b0, 1'b1, 0));
    applyStimulus(beats);
    reset       = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_last  = 1'b1;
    bus.i_ack   = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_ack   = 1'b0;
    chk("midrst_in", {30'd0, bus.o_ready, bus.o_done}, 32'd0);
    reset = 1'b0;
    chk("midrst_init", {30'd0, bus.o_ready, bus.o_done}, 32'd0);
    tick();
    chk("midrst_run", {30'd0, bus.o_ready, bus.o_done}, 32'b10);
    beats.delete();
    beats.push_back(mk(32'h0000_0000, 4'b0001, 1'b1, 1'b1, 0));
    applyStimulus(beats);
    chk("postrst_const", 32'(bus.o_crc), 32'h0000_00C7);
    checkOutput("postrst", beats, 0);

    beats.delete();
    beats.push_back(mk(32'h0000_0000, 4'b1111, 1'b0, 1'b1, 0));
    beats.push_back(mk(32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0, 1));
    applyStimulus(beats);
    checkOutput("keep0_mode", beats, 1);

    pre.delete();
    repeat (4) pre.push_back(8'h00);
    c = model_crc(pre);
    beats.delete();
    beats.push_back(mk(32'h0000_0000, 4'b1111, 1'b0, 1'b0, 0));
    beats.push_back(mk({24'hFFFFFF, c}, 4'b0001, 1'b1, 1'b1, 0));
    applyStimulus(beats);
    chk("mode_latch_const", 32'(bus.o_match), 32'd1);
    checkOutput("mode_latch", beats, 0);

    for (int f = 0; f < 24; f++) begin
      beats.delete();
      nb = $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
        beats.push_back(mk($urandom, 4'($urandom), 1'b0, 1'($urandom), $urandom_range(0, 2)));
      end
      good  = ($urandom_range(0, 1) == 1);
      nk    = $urandom_range(good ? 1 : 0, 4);
      kmask = (5'd1 << nk) - 5'd1;
      beats.push_back(mk($urandom, kmask[3:0], 1'b1, 1'($urandom), $urandom_range(0, 2)));
      beats[0].mode = good ? 1'b0 : 1'($urandom);
      if (good) begin
        beats[nb].keep = kmask[3:0];
        pre = frame_bytes(beats);
        void'(pre.pop_back());
        beats[nb].data[8*(nk-1) +: 8] = model_crc(pre);
      end
      applyStimulus(beats);
      checkOutput($sformatf("rand%0d", f), beats, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
